// File: rtl/cpu_alu_pkg.sv
// Shared opcode encodings, FSM states and default width for the execute/writeback stage.
package cpu_alu_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_seq #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int unsigned CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W-1:0]   mplier;
    logic [CW-1:0]       cnt;
    logic                running;

    // Final step is folded in combinationally so the product is usable on the last edge.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = running && (cnt == LAST);
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            mcand   <= {{DATA_W{1'b0}}, a};
            mplier  <= b;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_writeback.sv
// Execute/writeback stage: IDLE -> EXEC -> WB, single-cycle ALU ops plus optional
// iterative MUL (ALU_MUL_EN defined); without ALU_MUL_EN opcode 111 is a NOP.
module alu_writeback #(
    parameter int unsigned DATA_W = cpu_alu_pkg::DATA_W,
    parameter int unsigned NREG   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic [DATA_W-1:0] rd_q,
    input  logic [DATA_W-1:0] rs_q,
    input  logic [2:0]        op,
    input  logic [1:0]        rd,
    output logic [DATA_W-1:0] alu_out,
    output logic [NREG-1:0]   reg_en,
    output logic              en_out,
    output logic              busy,
    output logic              zf,
    output logic              cf
);

    import cpu_alu_pkg::*;

    localparam int unsigned RD_W = 2;
    localparam int unsigned SHW  = $clog2(DATA_W);

    state_t              state;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [2:0]          op_q;
    logic [RD_W-1:0]     rd_sel;

    logic [DATA_W-1:0]   res;
    logic                res_cf;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [DATA_W:0]     wide_l;
    logic [DATA_W:0]     wide_r;
    logic [SHW-1:0]      sh;
    logic                fin;
    logic                wr;
    logic [DATA_W-1:0]   wr_val;
    logic                wr_cf;
    logic [NREG-1:0]     onehot;

`ifdef ALU_MUL_EN
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_prod;

    // Multiplier starts from the live operands on the same edge that latches them.
    assign mul_start = (state == IDLE) && en_in && (op == OP_MUL);

    alu_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (rd_q),
        .b       (rs_q),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    assign onehot = {{(NREG-1){1'b0}}, 1'b1} << rd_sel;

    always_comb begin
        sh     = b_q[SHW-1:0];
        sum    = {1'b0, a_q} + {1'b0, b_q};
        diff   = {1'b0, a_q} - {1'b0, b_q};
        // Extra bit on each side catches the last bit shifted out; zero when sh == 0.
        wide_l = {1'b0, a_q} << sh;
        wide_r = {a_q, 1'b0} >> sh;
        res    = '0;
        res_cf = 1'b0;
        case (op_q)
            OP_ADD:  {res_cf, res} = sum;
            OP_SUB:  {res_cf, res} = diff;
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_MOV:  res = b_q;
            OP_SHL: begin
                res    = wide_l[DATA_W-1:0];
                res_cf = wide_l[DATA_W];
            end
            OP_SHR: begin
                res    = wide_r[DATA_W:1];
                res_cf = wide_r[0];
            end
            default: begin
                res    = '0;
                res_cf = 1'b0;
            end
        endcase

        fin    = 1'b1;
        wr     = 1'b1;
        wr_val = res;
        wr_cf  = res_cf;
        if (op_q == OP_MUL) begin
`ifdef ALU_MUL_EN
            fin    = mul_done;
            wr_val = mul_prod[DATA_W-1:0];
            wr_cf  = |mul_prod[2*DATA_W-1:DATA_W];
`else
            wr     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rd_sel  <= '0;
            alu_out <= '0;
            reg_en  <= '0;
            en_out  <= 1'b0;
            busy    <= 1'b0;
            zf      <= 1'b0;
            cf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_in) begin
                        a_q    <= rd_q;
                        b_q    <= rs_q;
                        op_q   <= op;
                        rd_sel <= rd;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (fin) begin
                        en_out <= 1'b1;
                        state  <= WB;
                        if (wr) begin
                            alu_out <= wr_val;
                            zf      <= (wr_val == '0);
                            cf      <= wr_cf;
                            reg_en  <= onehot;
                        end
                    end
                end
                WB: begin
                    reg_en <= '0;
                    en_out <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    reg_en <= '0;
                    en_out <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback; adapts to ALU_MUL_EN.
module tb_alu_writeback;

    import cpu_alu_pkg::*;

`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_in = 1'b0;
    logic [15:0] rd_q = '0;
    logic [15:0] rs_q = '0;
    logic [2:0]  op = '0;
    logic [1:0]  rd = '0;
    logic [15:0] alu_out;
    logic [3:0]  reg_en;
    logic        en_out;
    logic        busy;
    logic        zf;
    logic        cf;

    always #5 clk = ~clk;

    alu_writeback #(
        .DATA_W (16),
        .NREG   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en_in   (en_in),
        .rd_q    (rd_q),
        .rs_q    (rs_q),
        .op      (op),
        .rd      (rd),
        .alu_out (alu_out),
        .reg_en  (reg_en),
        .en_out  (en_out),
        .busy    (busy),
        .zf      (zf),
        .cf      (cf)
    );

    typedef struct {
        logic [15:0] alu;
        logic [3:0]  ren;
        logic        zf;
        logic        cf;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] m_alu = '0;
    logic        m_zf = 1'b0;
    logic        m_cf = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic, updates held result/flags on writes.
    task automatic issue(input logic [2:0] o, input logic [1:0] r,
                         input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] w;
        logic [15:0] res;
        logic        c;
        bit          write;
        int          n;
        int          t;
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_val("busy_timeout", busy, 0);
        write = 1'b1;
        res   = '0;
        c     = 1'b0;
        n     = int'(b[3:0]);
        case (o)
            OP_ADD: begin w = 32'(a) + 32'(b); res = w[15:0]; c = (w > 32'hFFFF); end
            OP_SUB: begin res = a - b; c = (a < b); end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_MOV: res = b;
            OP_SHL: begin res = a << n; c = (n != 0) ? a[16 - n] : 1'b0; end
            OP_SHR: begin res = a >> n; c = (n != 0) ? a[n - 1] : 1'b0; end
            default: begin
                if (MUL_ON) begin
                    w = 32'(a) * 32'(b);
                    res = w[15:0];
                    c = (w[31:16] != 0);
                end else begin
                    write = 1'b0;
                end
            end
        endcase
        if (write) begin
            m_alu = res;
            m_zf  = (res == 16'h0000);
            m_cf  = c;
            e.ren = 4'b0001 << r;
        end else begin
            e.ren = 4'b0000;
        end
        e.alu = m_alu;
        e.zf  = m_zf;
        e.cf  = m_cf;
        e.lat = (o == OP_MUL && MUL_ON) ? 17 : 2;
        e.t0  = cyc;
        sb.push_back(e);
        en_in = 1'b1;
        op    = o;
        rd    = r;
        rd_q  = a;
        rs_q  = b;
        @(negedge clk);
        en_in = 1'b0;
    endtask

    task automatic run(input logic [2:0] o, input logic [1:0] r,
                       input logic [15:0] a, input logic [15:0] b, input bit inject);
        int n;
        issue(o, r, a, b);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (inject) begin
                en_in = 1'b1;
                op    = OP_MOV;
                rd    = ~r;
                rd_q  = 16'h1234;
                rs_q  = 16'h5A5A;
            end
            @(negedge clk);
        end
        en_in = 1'b0;
        check_val("busy_cycles", n, (o == OP_MUL && MUL_ON) ? 17 : 2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (en_out) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_en_out", en_out, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("alu_out", alu_out, e.alu);
                    check_val("reg_en", reg_en, e.ren);
                    check_val("zf", zf, e.zf);
                    check_val("cf", cf, e.cf);
                    check_val("latency", cyc - e.t0, e.lat);
                end
            end else begin
                check_val("idle_reg_en", reg_en, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_val("rst_alu_out", alu_out, 0);
        check_val("rst_reg_en", reg_en, 0);
        check_val("rst_en_out", en_out, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_zf", zf, 0);
        check_val("rst_cf", cf, 0);
        rst = 1'b1;
        @(negedge clk);

        run(OP_ADD, 2'd2, 16'hFFFF, 16'h0001, 1'b0);
        run(OP_SUB, 2'd0, 16'h0003, 16'h0005, 1'b0);
        run(OP_AND, 2'd1, 16'hF0F0, 16'hFF00, 1'b0);
        run(OP_OR,  2'd1, 16'hF0F0, 16'h0F0F, 1'b0);
        run(OP_MOV, 2'd3, 16'hBEEF, 16'h0000, 1'b0);
        run(OP_SHL, 2'd3, 16'h8001, 16'h0001, 1'b0);
        run(OP_SHR, 2'd2, 16'h8001, 16'h0000, 1'b0);
        run(OP_SHR, 2'd1, 16'h0003, 16'h0002, 1'b0);
        run(OP_SHL, 2'd0, 16'h1235, 16'h001F, 1'b0);
        run(OP_MUL, 2'd1, 16'h0100, 16'h0100, 1'b0);
        run(OP_MUL, 2'd2, 16'h1234, 16'h0003, 1'b0);
        run(OP_ADD, 2'd0, 16'h0001, 16'h0002, 1'b1);
        run(OP_MUL, 2'd3, 16'hFFFF, 16'hFFFF, 1'b1);

        for (int i = 0; i < 24; i++) begin
            run(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                16'($urandom), 16'($urandom), 1'b0);
        end

        // Abort mid-operation: nonzero state first, then reset during EXEC.
        run(OP_ADD, 2'd3, 16'hFFFF, 16'h0002, 1'b0);
        issue(MUL_ON ? OP_MUL : OP_ADD, 2'd1, 16'h00FF, 16'h0101);
        repeat (MUL_ON ? 7 : 0) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("abort_alu_out", alu_out, 0);
        check_val("abort_reg_en", reg_en, 0);
        check_val("abort_en_out", en_out, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_zf", zf, 0);
        check_val("abort_cf", cf, 0);
        sb.delete();
        m_alu = '0;
        m_zf  = 1'b0;
        m_cf  = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (25) @(negedge clk);
        check_val("post_abort_busy", busy, 0);
        check_val("post_abort_alu_out", alu_out, 0);

        run(OP_OR, 2'd2, 16'h00F0, 16'h0F00, 1'b0);
        repeat (4) @(negedge clk);
        check_val("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
